// File: rtl/wide_addsub_seq.sv
// Sequential W-bit add/subtract built from one external 16-bit adder slice,
// processing one slice per cycle from least to most significant.
module wide_addsub_seq #(
   parameter int NSLICES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [16*NSLICES-1:0]   in_a,
   input  logic [16*NSLICES-1:0]   in_b,
   input  logic                    in_sub,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [16*NSLICES-1:0]   out_sum,
   output logic                    out_cout,
   output logic                    out_ovf,
   output logic [15:0]             add_x1,
   output logic [15:0]             add_x2,
   output logic                    add_cin,
   input  logic [15:0]             add_s,
   input  logic                    add_p,
   input  logic                    add_g
);

   localparam int W  = 16 * NSLICES;
   localparam int KW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NSLICES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q;
   logic [KW-1:0]   k_q;
   logic            c_q;
   logic            c_d;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    res_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [15:0]     x1_d;
   logic [15:0]     x2_d;

   // c holds the carry into the current slice; b_q is already inverted for subtract.
   assign c_d  = add_g | (add_p & c_q);
   assign x1_d = a_q[k_q*16 +: 16];
   assign x2_d = b_q[k_q*16 +: 16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         c_q         <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= in_a;
                  b_q        <= in_sub ? ~in_b : in_b;
                  c_q        <= in_sub;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               res_q[k_q*16 +: 16] <= add_s;
               c_q                 <= c_d;
               if (k_q == KLAST) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = res_q;
   assign out_cout  = c_q;
   assign out_ovf   = (a_q[W-1] ^ res_q[W-1]) & (b_q[W-1] ^ res_q[W-1]);

   assign add_x1  = (state_q == RUN) ? x1_d : 16'h0;
   assign add_x2  = (state_q == RUN) ? x2_d : 16'h0;
   assign add_cin = (state_q == RUN) ? c_q  : 1'b0;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Bench for wide_addsub_seq with NSLICES=4 and a behavioural 16-bit slice.
// Vector table plus hand sequences for backpressure, busy ignore and reset.
module tb_wide_addsub_seq;

   localparam int NS = 4;
   localparam int W  = 16 * NS;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic [15:0]   add_x1;
   logic [15:0]   add_x2;
   logic          add_cin;
   logic [15:0]   add_s;
   logic          add_p;
   logic          add_g;
   logic [16:0]   gsum;

   wide_addsub_seq #(.NSLICES(NS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .add_x1    (add_x1),
      .add_x2    (add_x2),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_p     (add_p),
      .add_g     (add_g)
   );

   // Slice model: full-slice sum, propagate when every bit differs,
   // generate when the slice carries out with no carry in.
   always_comb begin
      gsum  = {1'b0, add_x1} + {1'b0, add_x2};
      add_s = add_x1 + add_x2 + {15'h0, add_cin};
      add_p = &(add_x1 ^ add_x2);
      add_g = gsum[16];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   int   nchk;
   int   nerr;
   exp_t sb[$];
   logic cin_log[$];
   vec_t vt[9];

   function automatic void chk(input string nm, input logic [W-1:0] act,
                               input logic [W-1:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input exp_t e);
      chk("in_ready_before_accept", W'(in_ready), W'(1));
      in_a     = a;
      in_b     = b;
      in_sub   = s;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic recv(input int hold, input bit poke);
      int   n;
      exp_t e;
      n = 0;
      cin_log.delete();
      while (!out_valid && n < 20) begin
         cin_log.push_back(add_cin);
         if (poke) begin
            in_valid = 1'b1;
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            in_sub   = 1'($urandom);
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("latency", W'(n), W'(NS));
      if (sb.size() == 0) begin
         nchk++;
         nerr++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
         e = '{sum: '0, cout: 1'b0, ovf: 1'b0};
      end else begin
         e = sb.pop_front();
      end
      chk("sum", out_sum, e.sum);
      chk("cout", W'(out_cout), W'(e.cout));
      chk("ovf", W'(out_ovf), W'(e.ovf));
      chk("x1_done_zero", W'({add_x1, add_x2, add_cin}), W'(0));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_valid", W'(out_valid), W'(1));
         chk("hold_in_ready", W'(in_ready), W'(0));
         chk("hold_sum", out_sum, e.sum);
         chk("hold_flags", W'({out_cout, out_ovf}), W'({e.cout, e.ovf}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_fall", W'(out_valid), W'(0));
      chk("ready_rise", W'(in_ready), W'(1));
      chk("x1_idle_zero", W'({add_x1, add_x2, add_cin}), W'(0));
   endtask

   initial begin
      exp_t e;
      nchk      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b0;

      vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
      vt[1] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vt[2] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vt[4] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
      vt[5] = '{64'h0000_0001_0000_FFFF, 64'h1, 1'b0,
                64'h0000_0001_0001_0000, 1'b0, 1'b0};
      vt[6] = '{64'hA, 64'h3, 1'b1, 64'h7, 1'b1, 1'b0};
      vt[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
      vt[8] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
                64'h0, 1'b1, 1'b0};

      #12;
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_sum", out_sum, W'(0));
      chk("rst_flags", W'({out_cout, out_ovf}), W'(0));
      chk("rst_adder", W'({add_x1, add_x2, add_cin}), W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         e = '{sum: vt[i].sum, cout: vt[i].cout, ovf: vt[i].ovf};
         send(vt[i].a, vt[i].b, vt[i].sub, e);
         recv(0, 1'b0);
         if (i == 0) begin
            if (cin_log.size() == 4)
               chk("cin_seq",
                   W'({cin_log[0], cin_log[1], cin_log[2], cin_log[3]}),
                   W'(4'b0111));
            else
               chk("cin_count", W'(cin_log.size()), W'(4));
         end
      end

      e = '{sum: 64'h2222_2222_2222_2211, cout: 1'b0, ovf: 1'b0};
      send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, e);
      recv(5, 1'b0);

      e = '{sum: 64'h0000_0000_0000_0007, cout: 1'b1, ovf: 1'b0};
      send(64'hA, 64'h3, 1'b1, e);
      recv(2, 1'b1);

      e = '{sum: 64'h2222_2222_2222_2222, cout: 1'b0, ovf: 1'b0};
      send(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, e);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("abort_out_valid", W'(out_valid), W'(0));
      chk("abort_in_ready", W'(in_ready), W'(1));
      chk("abort_out_sum", out_sum, W'(0));
      chk("abort_flags", W'({out_cout, out_ovf}), W'(0));
      chk("abort_adder", W'({add_x1, add_x2, add_cin}), W'(0));
      #1;
      rst_n = 1'b1;
      e = '{sum: 64'h8, cout: 1'b0, ovf: 1'b0};
      send(64'h5, 64'h3, 1'b0, e);
      recv(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
